// File: rtl/rotxor_pkg.sv
// Shared types and helpers for the rotate/XOR digest sequencer.
package rotxor_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int RW_DEF    = 5;
  localparam int LW_DEF    = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [WIDTH_DEF-1:0] rotl(input logic [WIDTH_DEF-1:0] a,
                                                input logic [RW_DEF-1:0]    amt);
    return (a << amt) | (a >> (WIDTH_DEF - int'(amt)));
  endfunction

endpackage

// File: rtl/rotl_xor_unit.sv
// Combinational fold step: rotate i_a left by i_amt, then XOR with i_b.
module rotl_xor_unit #(
  parameter int WIDTH = 32,
  parameter int RW    = 5
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [RW-1:0]    i_amt,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_y
);

  logic [WIDTH-1:0] w_rot;

  // A right shift by the full width yields zero, so amt==0 falls out as identity.
  assign w_rot = (i_a << i_amt) | (i_a >> (WIDTH - int'(i_amt)));
  assign o_y   = w_rot ^ i_b;

endmodule

// File: rtl/rotxor_seq.sv
// Folds a job of words into acc = rotl(acc, rot) ^ word and hands out the digest.
//   state   | meaning
//   IDLE    | waiting for start; outputs quiet
//   RUN     | accepting words, one per cycle, cnt counts down to the last word
//   DONE    | digest presented on out_data until the consumer takes it
module rotxor_seq
  import rotxor_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int RW    = RW_DEF,
  parameter int LW    = LW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] seed,
  input  logic [RW-1:0]    rot_amt,
  input  logic [LW-1:0]    len,
  input  logic             abort,
  output logic             busy,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_acc, w_acc_nxt;
  logic [RW-1:0]    r_rot, w_rot_nxt;
  logic [LW-1:0]    r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] w_fold;
  logic             w_accept;

  rotl_xor_unit #(.WIDTH(WIDTH), .RW(RW)) u_fold (
    .i_a  (r_acc),
    .i_amt(r_rot),
    .i_b  (in_data),
    .o_y  (w_fold)
  );

  assign busy      = (r_state != ST_IDLE);
  assign in_ready  = (r_state == ST_RUN);
  assign out_valid = (r_state == ST_DONE);
  assign out_data  = out_valid ? r_acc : '0;
  assign w_accept  = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
      r_rot   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_rot   <= w_rot_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_rot_nxt   = r_rot;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_acc_nxt   = seed;
          w_rot_nxt   = rot_amt;
          w_cnt_nxt   = len;
          w_state_nxt = (len == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        // abort beats a coincident accept: the word is consumed but dropped
        if (abort) begin
          w_acc_nxt   = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end else if (w_accept) begin
          w_acc_nxt = w_fold;
          w_cnt_nxt = r_cnt - LW'(1);
          if (r_cnt == LW'(1)) w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end else if (abort) begin
          w_acc_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_rotxor_seq.sv
// Directed plus randomized checks of rotxor_seq against a plain-arithmetic digest model.
module tb_rotxor_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] seed = '0;
  logic [4:0]  rot_amt = '0;
  logic [7:0]  len = '0;
  logic        abort = 1'b0;
  logic        busy;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;

  rotxor_seq dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed), .rot_amt(rot_amt),
    .len(len), .abort(abort), .busy(busy), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_digest(input logic [31:0] s, input int r,
                                             input logic [31:0] w[$]);
    logic [63:0] a;
    a = {32'd0, s};
    foreach (w[k]) begin
      // rotate via multiply-and-fold on a 64-bit scratch value
      a = a * (64'd1 << r);
      a = {32'd0, a[31:0] | a[63:32]} ^ {32'd0, w[k]};
    end
    return a[31:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one job from IDLE to digest handshake; in_mode 0 = valid every cycle, 1 = random gaps.
  task automatic run_job(input string tag, input logic [31:0] sd, input logic [4:0] rt,
                         input logic [31:0] w[$], input logic [31:0] exp_dig,
                         input int in_mode, input int hold, input bit start_in_hold,
                         input bit abort_with_start);
    int i;
    int cyc;
    start = 1'b1; seed = sd; rot_amt = rt; len = 8'(w.size());
    abort = abort_with_start;
    step();
    start = 1'b0; abort = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    i = 0; cyc = 0;
    while (i < w.size() && cyc < 200) begin
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      chk({tag, "_early_out_valid"}, 32'(out_valid), 32'd0);
      in_valid = (in_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      in_data  = in_valid ? w[i] : $urandom;
      step();
      if (in_valid) i++;
      cyc++;
    end
    in_valid = 1'b0;
    chk({tag, "_no_timeout"}, 32'(cyc < 200), 32'd1);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);
    chk({tag, "_digest"}, out_data, exp_dig);
    for (int h = 0; h < hold; h++) begin
      if (start_in_hold && h == 1) begin
        start = 1'b1; seed = ~sd; len = 8'd3;
      end
      step();
      start = 1'b0;
      chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_hold_data"}, out_data, exp_dig);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    chk({tag, "_idle_data"}, out_data, 32'd0);
  endtask

  initial begin
    logic [31:0] q[$];
    logic [31:0] sd;
    logic [4:0]  rt;
    int          n;

    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    step();
    rst = 1'b0;
    step();

    q = '{32'h0000FFFF, 32'hFFFF0000};
    run_job("t1", 32'h0, 5'd0, q, 32'hFFFFFFFF, 0, 0, 1'b0, 1'b0);
    q = '{32'h0};
    run_job("t2", 32'h12345678, 5'd4, q, 32'h23456781, 0, 0, 1'b0, 1'b0);
    q = '{32'h0, 32'h0};
    run_job("t3", 32'h80000001, 5'd1, q, 32'h00000006, 0, 2, 1'b0, 1'b0);
    q = {};
    run_job("t4_len0", 32'hDEADBEEF, 5'd7, q, 32'hDEADBEEF, 0, 5, 1'b1, 1'b0);

    // abort after two accepts with in_valid toggling; the coincident word is dropped
    start = 1'b1; seed = 32'hA5A5A5A5; rot_amt = 5'd3; len = 8'd3;
    step();
    start = 1'b0;
    n = 0;
    for (int c = 0; c < 3; c++) begin
      in_valid = (c % 2 == 0); in_data = $urandom;
      step();
      if (in_valid) n++;
    end
    chk("ab_accepts", 32'(n), 32'd2);
    chk("ab_still_run", 32'(in_ready), 32'd1);
    in_valid = 1'b1; abort = 1'b1;
    step();
    in_valid = 1'b0; abort = 1'b0;
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_out_valid", 32'(out_valid), 32'd0);
    chk("ab_in_ready", 32'(in_ready), 32'd0);
    repeat (3) begin
      step();
      chk("ab_quiet", 32'(out_valid | busy), 32'd0);
    end
    sd = $urandom; q = '{$urandom, $urandom};
    run_job("ab_next", sd, 5'd9, q, ref_digest(sd, 9, q), 1, 1, 1'b0, 1'b1);

    // abort in DONE without out_ready drops the digest
    start = 1'b1; seed = 32'h13579BDF; len = 8'd0;
    step();
    start = 1'b0;
    chk("abd_valid", 32'(out_valid), 32'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abd_gone", 32'(out_valid | busy), 32'd0);

    // abort together with the out handshake still completes the handshake
    q = '{32'h0F0F0F0F};
    start = 1'b1; seed = 32'h1; rot_amt = 5'd31; len = 8'd1;
    step();
    start = 1'b0; in_valid = 1'b1; in_data = q[0];
    step();
    in_valid = 1'b0;
    chk("abh_data", out_data, ref_digest(32'h1, 31, q));
    abort = 1'b1; out_ready = 1'b1;
    step();
    abort = 1'b0; out_ready = 1'b0;
    chk("abh_idle", 32'(out_valid | busy), 32'd0);

    // async reset mid-RUN
    start = 1'b1; seed = $urandom; rot_amt = 5'd5; len = 8'd4;
    step();
    start = 1'b0; in_valid = 1'b1;
    repeat (2) begin
      in_data = $urandom;
      step();
    end
    in_valid = 1'b0;
    chk("rr_in_ready_pre", 32'(in_ready), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rr_busy", 32'(busy), 32'd0);
    chk("rr_in_ready", 32'(in_ready), 32'd0);
    chk("rr_out_valid", 32'(out_valid), 32'd0);
    step();
    rst = 1'b0;
    step();
    q = '{32'h1};
    run_job("rr_fresh", 32'h1, 5'd0, q, 32'h0, 0, 0, 1'b0, 1'b0);

    for (int j = 0; j < 20; j++) begin
      sd = $urandom;
      rt = 5'($urandom_range(0, 31));
      n  = $urandom_range(0, 12);
      q  = {};
      for (int k = 0; k < n; k++) q.push_back($urandom);
      run_job($sformatf("rnd%0d", j), sd, rt, q, ref_digest(sd, int'(rt), q),
              1, $urandom_range(0, 3), 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
